// File: rtl/conv2d_filter_output_arbiter.sv
// Per-filter skid buffers drained into one shared feature-map FIFO with a source tag.
// Define ARB_STRICT_ORDER_EN for strict 0..N-1 interleave; default is work-conserving round robin.
module conv2d_filter_output_arbiter #(
    parameter int unsigned NUM_FILTERS  = 4,
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned BUF_DEPTH    = 4,
    parameter int unsigned AFULL_THRESH = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_FILTERS*DWIDTH-1:0]   flt_wdata,
    input  logic [NUM_FILTERS-1:0]          flt_wrreq,
    output logic [NUM_FILTERS-1:0]          flt_stall,
    output logic [DWIDTH-1:0]               out_wdata,
    output logic [$clog2(NUM_FILTERS)-1:0]  out_tag,
    output logic                            out_wrreq,
    input  logic                            out_full,
    output logic                            pixel_done,
    output logic                            overflow_err
);

    localparam int unsigned TAG_W = $clog2(NUM_FILTERS);
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(BUF_DEPTH - AFULL_THRESH);
    localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(NUM_FILTERS - 1);

    logic [DWIDTH-1:0]      mem_q  [NUM_FILTERS][BUF_DEPTH];
    logic [PTR_W-1:0]       wptr_q [NUM_FILTERS];
    logic [PTR_W-1:0]       rptr_q [NUM_FILTERS];
    logic [CNT_W-1:0]       cnt_q  [NUM_FILTERS];
    logic [CNT_W-1:0]       cnt_d  [NUM_FILTERS];
    logic [NUM_FILTERS-1:0] push;
    logic [NUM_FILTERS-1:0] pop;
    logic [NUM_FILTERS-1:0] drop;
    logic [NUM_FILTERS-1:0] not_empty;
    logic [NUM_FILTERS-1:0] stall_d;
    logic [TAG_W-1:0]       rr_q;
    logic [TAG_W-1:0]       rr_d;
    logic [TAG_W-1:0]       grant_idx;
    logic                   grant_vld;
    logic [DWIDTH-1:0]      grant_data;

    always_comb begin
        for (int i = 0; i < NUM_FILTERS; i++) begin
            not_empty[i] = (cnt_q[i] != '0);
        end
    end

`ifdef ARB_STRICT_ORDER_EN
    // Wait on rr_q even if other buffers hold data, keeping channel order fixed.
    always_comb begin
        grant_idx = rr_q;
        grant_vld = !out_full && not_empty[rr_q];
    end
`else
    logic [TAG_W:0] cand;

    always_comb begin
        grant_idx = rr_q;
        grant_vld = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_FILTERS; k++) begin
            cand = {1'b0, rr_q} + (TAG_W+1)'(k);
            if (cand >= (TAG_W+1)'(NUM_FILTERS)) begin
                cand = cand - (TAG_W+1)'(NUM_FILTERS);
            end
            if (!grant_vld && not_empty[cand[TAG_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[TAG_W-1:0];
            end
        end
        if (out_full) begin
            grant_vld = 1'b0;
        end
    end
`endif

    assign grant_data = mem_q[grant_idx][rptr_q[grant_idx]];

    always_comb begin
        for (int i = 0; i < NUM_FILTERS; i++) begin
            pop[i]   = grant_vld && (grant_idx == TAG_W'(i));
            // A full buffer still accepts a push when it pops in the same cycle.
            push[i]  = flt_wrreq[i] && ((cnt_q[i] != FULL_CNT) || pop[i]);
            drop[i]  = flt_wrreq[i] && !push[i];
            cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            stall_d[i] = (cnt_d[i] >= STALL_CNT);
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant_vld) begin
            rr_d = (grant_idx == LAST_TAG) ? '0 : grant_idx + TAG_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_FILTERS; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= flt_wdata[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FILTERS; i++) begin
                if (push[i]) begin
                    wptr_q[i] <= wptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rptr_q[i] <= rptr_q[i] + PTR_W'(1);
                end
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q         <= '0;
            out_wdata    <= '0;
            out_tag      <= '0;
            out_wrreq    <= 1'b0;
            pixel_done   <= 1'b0;
            flt_stall    <= '0;
            overflow_err <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            out_wrreq    <= grant_vld;
            pixel_done   <= grant_vld && (grant_idx == LAST_TAG);
            flt_stall    <= stall_d;
            overflow_err <= overflow_err | (|drop);
            if (grant_vld) begin
                out_wdata <= grant_data;
                out_tag   <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_filter_output_arbiter.sv
// Scoreboard bench for conv2d_filter_output_arbiter (4 filters, 32-bit words, depth-4 buffers).
module tb_conv2d_filter_output_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [N*W-1:0]   flt_wdata;
    logic [N-1:0]     flt_wrreq;
    logic [N-1:0]     flt_stall;
    logic [W-1:0]     out_wdata;
    logic [1:0]       out_tag;
    logic             out_wrreq;
    logic             out_full;
    logic             pixel_done;
    logic             overflow_err;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  t;
        logic        pd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    conv2d_filter_output_arbiter #(
        .NUM_FILTERS (N),
        .DWIDTH      (W),
        .BUF_DEPTH   (4),
        .AFULL_THRESH(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .flt_wdata   (flt_wdata),
        .flt_wrreq   (flt_wrreq),
        .flt_stall   (flt_stall),
        .out_wdata   (out_wdata),
        .out_tag     (out_tag),
        .out_wrreq   (out_wrreq),
        .out_full    (out_full),
        .pixel_done  (pixel_done),
        .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_word(input logic [31:0] d, input int t);
        exp_t e;
        e.d  = d;
        e.t  = 2'(t);
        e.pd = (t == N - 1);
        sb.push_back(e);
    endtask

    task automatic set_word(input int f, input logic [31:0] d);
        flt_wdata[f*W +: W] = d;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clock);
        chk(name, 32'(sb.size()), 0);
    endtask

    initial begin
        reset     = 1'b1;
        flt_wdata = '0;
        flt_wrreq = '0;
        out_full  = 1'b0;
        #2 reset  = 1'b0;

        // Monitor: every written word must match the head of the scoreboard.
        fork
            forever begin
                @(negedge clock);
                if (out_wrreq === 1'b1) begin
                    if (sb.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_write: got data 0x%0h tag %0d, expected no write",
                                 out_wdata, out_tag);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("out_wdata", out_wdata, mon_e.d);
                        chk("out_tag", 32'(out_tag), 32'(mon_e.t));
                        chk("pixel_done", 32'(pixel_done), 32'(mon_e.pd));
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_out_wrreq", 32'(out_wrreq), 0);
        chk("rst_out_wdata", out_wdata, 0);
        chk("rst_out_tag", 32'(out_tag), 0);
        chk("rst_pixel_done", 32'(pixel_done), 0);
        chk("rst_flt_stall", 32'(flt_stall), 0);
        chk("rst_overflow_err", 32'(overflow_err), 0);
        reset = 1'b1;

        // All four filters push in one cycle; four back-to-back writes
        @(negedge clock);
        set_word(0, 32'hA0); set_word(1, 32'hB0); set_word(2, 32'hC0); set_word(3, 32'hD0);
        flt_wrreq = 4'hF;
        expect_word(32'hA0, 0); expect_word(32'hB0, 1);
        expect_word(32'hC0, 2); expect_word(32'hD0, 3);
        @(negedge clock);
        flt_wrreq = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("burst_wrreq_high", 32'(out_wrreq), 1);
        end
        @(negedge clock);
        chk("burst_wrreq_low", 32'(out_wrreq), 0);
        drain("drain_burst");

`ifndef ARB_STRICT_ORDER_EN
        // Filter 2 overfills while the shared FIFO is full
        @(negedge clock);
        out_full = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (k == 1) chk("stall_after_1", 32'(flt_stall[2]), 0);
            if (k == 2) chk("stall_after_2", 32'(flt_stall[2]), 1);
            if (k == 4) chk("ovf_before_drop", 32'(overflow_err), 0);
            if (k == 5) chk("ovf_after_drop", 32'(overflow_err), 1);
            set_word(2, 32'(32'h20 + k));
            flt_wrreq = 4'b0100;
        end
        @(negedge clock);
        flt_wrreq = '0;
        chk("ovf_set", 32'(overflow_err), 1);
        chk("stall_full", 32'(flt_stall[2]), 1);
        chk("no_write_when_full", 32'(out_wrreq), 0);
        for (int k = 0; k < 4; k++) expect_word(32'(32'h20 + k), 2);
        out_full = 1'b0;
        drain("drain_overfill");
        repeat (2) @(negedge clock);
        chk("ovf_sticky", 32'(overflow_err), 1);
        chk("stall_released", 32'(flt_stall), 0);
`endif

`ifdef ARB_STRICT_ORDER_EN
        // Strict: filter 1 waits until filter 0 supplies its word
        @(negedge clock);
        set_word(1, 32'h11);
        flt_wrreq = 4'b0010;
        @(negedge clock);
        flt_wrreq = '0;
        repeat (5) @(negedge clock);
        chk("strict_wait", 32'(out_wrreq), 0);
        set_word(0, 32'h01);
        flt_wrreq = 4'b0001;
        expect_word(32'h01, 0); expect_word(32'h11, 1);
        @(negedge clock);
        flt_wrreq = '0;
        @(negedge clock);
        chk("strict_first", 32'(out_wrreq), 1);
        @(negedge clock);
        chk("strict_second", 32'(out_wrreq), 1);
        drain("drain_strict");
`else
        // Work-conserving: filter 1 alone is served immediately
        @(negedge clock);
        set_word(1, 32'h11);
        flt_wrreq = 4'b0010;
        expect_word(32'h11, 1);
        @(negedge clock);
        flt_wrreq = '0;
        chk("wc_latency_pre", 32'(out_wrreq), 0);
        @(negedge clock);
        chk("wc_latency", 32'(out_wrreq), 1);
        drain("drain_wc");
        // rr pointer now 2: filter 3 must win over filter 1
        @(negedge clock);
        set_word(3, 32'h31); set_word(1, 32'h12);
        flt_wrreq = 4'b1010;
        expect_word(32'h31, 3); expect_word(32'h12, 1);
        @(negedge clock);
        flt_wrreq = '0;
        drain("drain_rr");

        // Full buffer with simultaneous push and pop
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("ovf_cleared", 32'(overflow_err), 0);
        out_full = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            set_word(0, 32'(32'h50 + k));
            flt_wrreq = 4'b0001;
            expect_word(32'(32'h50 + k), 0);
        end
        @(negedge clock);
        chk("full_stall", 32'(flt_stall[0]), 1);
        set_word(0, 32'h54);
        out_full = 1'b0;
        expect_word(32'h54, 0);
        @(negedge clock);
        set_word(0, 32'h55);
        expect_word(32'h55, 0);
        @(negedge clock);
        flt_wrreq = '0;
        drain("drain_pushpop");
        chk("pushpop_no_ovf", 32'(overflow_err), 0);
`endif

        // Asynchronous reset mid-stream with three buffers loaded
        @(negedge clock);
        out_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            set_word(0, 32'(32'h60 + k)); set_word(1, 32'(32'h70 + k));
            set_word(2, 32'(32'h80 + k));
            flt_wrreq = 4'b0111;
        end
        @(negedge clock);
        flt_wrreq = '0;
        out_full  = 1'b0;
        @(posedge clock);
        #1;
        chk("pre_rst_wrreq", 32'(out_wrreq), 1);
        chk("pre_rst_stall", 32'(flt_stall), 32'h7);
        chk("pre_rst_ovf", 32'(overflow_err), 1);
`ifdef ARB_STRICT_ORDER_EN
        chk("pre_rst_tag", 32'(out_tag), 2);
        chk("pre_rst_data", out_wdata, 32'h80);
`else
        chk("pre_rst_tag", 32'(out_tag), 1);
        chk("pre_rst_data", out_wdata, 32'h70);
`endif
        #1 reset = 1'b0;
        #1;
        chk("async_rst_wrreq", 32'(out_wrreq), 0);
        chk("async_rst_stall", 32'(flt_stall), 0);
        chk("async_rst_ovf", 32'(overflow_err), 0);
        chk("async_rst_pixel_done", 32'(pixel_done), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        chk("no_stale_words", 32'(out_wrreq), 0);
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
